// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data memory arbiter.
// Port ids, FSM state codes and default widths.
package dmem_arbiter_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;
  localparam int LAT_W      = 4;

  localparam logic PORT_LSU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_RESP  = 2'd3;

  function automatic logic in_range(
    input logic [31:0] addr,
    input int          aw
  );
    return (addr >> aw) == 32'd0;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Two-way round-robin grant for the data memory arbiter.
// The pointer names the port that wins a tie.
module rr_arbiter2
  import dmem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       gnt_valid,
  output logic       gnt_id
);

  logic ptr;

  assign gnt_valid = |req;

  // A sole requester wins; on a tie the pointer decides.
  always_comb begin
    gnt_id = ptr;
    unique case (1'b1)
      req == 2'b01: gnt_id = PORT_LSU;
      req == 2'b10: gnt_id = PORT_DMA;
      default:      gnt_id = ptr;
    endcase
  end

  // After each grant the tie goes to the port that lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= PORT_LSU;
    end else if (advance) begin
      ptr <= ~gnt_id;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data memory arbiter, one access in flight.
// Strobes are held MEM_LAT cycles; read data is taken on the last.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic [31:0]       p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p0_we,
  output logic              p0_rsp_valid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,
  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic [31:0]       p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic              p1_we,
  output logic              p1_rsp_valid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic [31:0]       mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam logic [LAT_W-1:0] LAT_M1 =
    LAT_W'(MEM_LAT - 1);

  state_t            state;
  logic [LAT_W-1:0]  cnt;
  logic              port_q;
  logic              we_q;
  logic              err_q;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic              gnt_valid;
  logic              gnt_id;
  logic              idle;
  logic              accept;
  logic              strobe;
  logic              in_rsp;
  logic [31:0]       sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;
  logic              sel_ok;

  assign idle   = state == ST_IDLE;
  assign accept = idle & gnt_valid;

  rr_arbiter2 u_rr (
    .clk       (clk),
    .reset     (reset),
    .req       ({p1_req_valid, p0_req_valid}),
    .advance   (accept),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign p0_req_ready = accept & (gnt_id == PORT_LSU);
  assign p1_req_ready = accept & (gnt_id == PORT_DMA);

  assign sel_addr  = gnt_id ? p1_addr  : p0_addr;
  assign sel_wdata = gnt_id ? p1_wdata : p0_wdata;
  assign sel_we    = gnt_id ? p1_we    : p0_we;
  assign sel_ok    = in_range(sel_addr, ADDR_W);

  assign strobe         = mem_read | mem_write;
  assign mem_address    = strobe ? addr_q : '0;
  assign mem_write_data = mem_write ? wdata_q : '0;

  assign in_rsp       = state == ST_RESP;
  assign p0_rsp_valid = in_rsp & (port_q == PORT_LSU);
  assign p1_rsp_valid = in_rsp & (port_q == PORT_DMA);
  assign p0_rdata     = p0_rsp_valid ? rdata_q : '0;
  assign p1_rdata     = p1_rsp_valid ? rdata_q : '0;
  assign p0_err       = p0_rsp_valid & err_q;
  assign p1_err       = p1_rsp_valid & err_q;

  // Transaction FSM: latch, strobe for MEM_LAT cycles, respond.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      port_q    <= PORT_LSU;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            port_q  <= gnt_id;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            we_q    <= sel_we;
            rdata_q <= '0;
            if (sel_ok) begin
              state     <= ST_ISSUE;
              cnt       <= LAT_M1;
              err_q     <= 1'b0;
              mem_write <= sel_we;
              mem_read  <= ~sel_we;
            end else begin
              state <= ST_RESP;
              err_q <= 1'b1;
            end
          end
        end
        ST_ISSUE, ST_WAIT: begin
          if (cnt == '0) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            rdata_q   <= we_q ? '0 : mem_read_data;
            state     <= ST_RESP;
          end else begin
            cnt   <= cnt - 1'b1;
            state <= ST_WAIT;
          end
        end
        ST_RESP: begin
          err_q <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter at MEM_LAT 1 and 3.
// Transaction-timing model plus directed literal expectations.
module tb_dmem_arbiter;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;
  localparam int NLOG = 12;

  logic clk = 1'b0;
  logic reset;
  logic mem_clr;

  always #5 clk = ~clk;

  logic [1:0]  vld  [2];
  logic [1:0]  we   [2];
  logic [31:0] addr [2][2];
  logic [31:0] wd   [2][2];

  wire  [1:0]  rdy   [2];
  wire  [1:0]  rsp   [2];
  wire  [1:0]  err   [2];
  wire  [31:0] rdata [2][2];
  wire  [31:0] maddr [2];
  wire  [31:0] mwd   [2];
  wire         mw    [2];
  wire         mr    [2];
  wire  [31:0] mrd   [2];

  logic [31:0] mem [2][1024];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dmem_arbiter #(
      .ADDR_W  (10),
      .DATA_W  (32),
      .MEM_LAT (g == 0 ? LAT0 : LAT1)
    ) u_dut (
      .clk            (clk),
      .reset          (reset),
      .p0_req_valid   (vld[g][0]),
      .p0_req_ready   (rdy[g][0]),
      .p0_addr        (addr[g][0]),
      .p0_wdata       (wd[g][0]),
      .p0_we          (we[g][0]),
      .p0_rsp_valid   (rsp[g][0]),
      .p0_rdata       (rdata[g][0]),
      .p0_err         (err[g][0]),
      .p1_req_valid   (vld[g][1]),
      .p1_req_ready   (rdy[g][1]),
      .p1_addr        (addr[g][1]),
      .p1_wdata       (wd[g][1]),
      .p1_we          (we[g][1]),
      .p1_rsp_valid   (rsp[g][1]),
      .p1_rdata       (rdata[g][1]),
      .p1_err         (err[g][1]),
      .mem_address    (maddr[g]),
      .mem_write_data (mwd[g]),
      .mem_write      (mw[g]),
      .mem_read       (mr[g]),
      .mem_read_data  (mrd[g])
    );
    assign mrd[g] = mem[g][maddr[g][9:0]];
  end

  // Memory behind each arbiter.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_clr) begin
        for (int i = 0; i < 1024; i++) mem[k][i] <= '0;
      end else if (mw[k]) begin
        mem[k][maddr[k][9:0]] <= mwd[k];
      end
    end
  end

  int checks;
  int errors;
  int cyc;
  logic live;
  logic mode_rand;

  bit          busy   [2];
  bit          rr     [2];
  int          n_acc  [2];
  logic        t_port [2];
  logic        t_we   [2];
  logic        t_err  [2];
  logic [31:0] t_addr [2];
  logic [31:0] t_wd   [2];
  logic [31:0] rmem   [2][1024];
  logic [1:0]  taken  [2];

  int          lg_n    [2];
  int          obs_acc [2];
  int          stb_cnt [2];
  logic        lg_port [2][NLOG];
  logic [31:0] lg_rd   [2][NLOG];
  logic        lg_err  [2][NLOG];
  int          lg_lat  [2][NLOG];
  int          lg_stb  [2][NLOG];

  int xp_port [9] = '{0, 1, 0, 1, 1, 0, 0, 1, 1};
  int xp_rd   [9] = '{0, 0, 12, 0, 'hA5, 0, 12, 'hA5, 'hA5};
  int xp_err  [9] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  task automatic chk(
    input string       nm,
    input int          k,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cyc %0d got %0h exp %0h",
               nm, k, cyc, got, exp);
    end
  endtask

  task automatic set_req(
    input int          p,
    input logic        w,
    input logic [31:0] a,
    input logic [31:0] d
  );
    for (int k = 0; k < 2; k++) begin
      vld[k][p]  = 1'b1;
      we[k][p]   = w;
      addr[k][p] = a;
      wd[k][p]   = d;
    end
  endtask

  task automatic run_cycle();
    bit   acc [2];
    logic ap  [2];
    bit   rst_now;
    int   d;
    int   last;
    logic [1:0]  er, ers;
    logic        eerr, emr, emw;
    logic [31:0] erd, ema;
    #1;
    rst_now = reset;
    for (int k = 0; k < 2; k++) begin
      acc[k] = 0;
      ap[k]  = 1'b0;
      if (!rst_now && live) begin
        er = '0; ers = '0; eerr = 0;
        emr = 0; emw = 0; erd = '0; ema = '0;
        d = cyc - n_acc[k];
        last = t_err[k] ? 1 : lat_of(k) + 1;
        if (!busy[k]) begin
          if (vld[k] == 2'b11) er = rr[k] ? 2'b10 : 2'b01;
          else er = vld[k];
        end else if (d == last) begin
          ers[t_port[k]] = 1'b1;
          eerr = t_err[k];
          if (!t_err[k] && !t_we[k])
            erd = rmem[k][t_addr[k][9:0]];
        end else if (!t_err[k] && d >= 1 && d <= lat_of(k)) begin
          emr = !t_we[k];
          emw = t_we[k];
          ema = t_addr[k];
        end
        chk("ready", k, 32'(rdy[k]), 32'(er));
        chk("rsp_valid", k, 32'(rsp[k]), 32'(ers));
        chk("err", k, 32'(err[k]), 32'(eerr ? ers : 2'b00));
        chk("p0_rdata", k, rdata[k][0], ers[0] ? erd : 32'd0);
        chk("p1_rdata", k, rdata[k][1], ers[1] ? erd : 32'd0);
        chk("mem_read", k, 32'(mr[k]), 32'(emr));
        chk("mem_write", k, 32'(mw[k]), 32'(emw));
        chk("mem_address", k, maddr[k], ema);
        if (emw) chk("mem_write_data", k, mwd[k], t_wd[k]);
        if (!busy[k] && vld[k] != 2'b00) begin
          acc[k] = 1;
          ap[k]  = (vld[k] == 2'b11) ? rr[k] : vld[k][1];
        end
        if ((vld[k] & rdy[k]) != 2'b00) obs_acc[k] = cyc;
        if (mr[k] || mw[k]) stb_cnt[k]++;
        if (rsp[k] != 2'b00 && lg_n[k] < NLOG) begin
          lg_port[k][lg_n[k]] = rsp[k][1];
          lg_rd[k][lg_n[k]]   = rsp[k][1] ? rdata[k][1]
                                          : rdata[k][0];
          lg_err[k][lg_n[k]]  = |err[k];
          lg_lat[k][lg_n[k]]  = cyc - obs_acc[k];
          lg_stb[k][lg_n[k]]  = stb_cnt[k];
          lg_n[k]++;
          stb_cnt[k] = 0;
        end
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      taken[k] = 2'b00;
      if (rst_now) begin
        busy[k]    = 0;
        rr[k]      = 0;
        stb_cnt[k] = 0;
      end else if (live) begin
        last = t_err[k] ? 1 : lat_of(k) + 1;
        if (busy[k] && cyc - n_acc[k] >= last) busy[k] = 0;
        if (acc[k]) begin
          busy[k]   = 1;
          n_acc[k]  = cyc;
          rr[k]     = !ap[k];
          t_port[k] = ap[k];
          t_we[k]   = we[k][ap[k]];
          t_addr[k] = addr[k][ap[k]];
          t_wd[k]   = wd[k][ap[k]];
          t_err[k]  = (t_addr[k] >> 10) != 32'd0;
          if (!t_err[k] && t_we[k])
            rmem[k][t_addr[k][9:0]] = t_wd[k];
          taken[k][ap[k]] = 1'b1;
        end
      end
    end
    @(negedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (taken[k][p]) vld[k][p] = 1'b0;
        if (!vld[k][p]) begin
          we[k][p]   = $urandom_range(0, 1) == 1;
          addr[k][p] = $urandom;
          wd[k][p]   = $urandom;
          if (mode_rand && $urandom_range(0, 2) == 0) begin
            case ($urandom_range(0, 7))
              0: addr[k][p] = $urandom | 32'h0000_0400;
              1: addr[k][p] = 32'($urandom_range(0, 1023));
              default: addr[k][p] = 32'($urandom_range(0, 15));
            endcase
            vld[k][p] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((vld[0] | vld[1]) != 2'b00 || busy[0] || busy[1]) begin
      if (n == 200) begin
        checks++;
        errors++;
        $display("FAIL idle_timeout cyc %0d got busy exp idle", cyc);
        return;
      end
      run_cycle();
      n++;
    end
  endtask

  initial begin
    reset = 1'b1;
    mem_clr = 1'b1;
    live = 1'b0;
    mode_rand = 1'b0;
    cyc = 0;
    checks = 0;
    errors = 0;
    for (int k = 0; k < 2; k++) begin
      vld[k] = '0;
      we[k] = '0;
      taken[k] = '0;
      busy[k] = 0;
      rr[k] = 0;
      n_acc[k] = 0;
      t_port[k] = 1'b0;
      t_we[k] = 1'b0;
      t_err[k] = 1'b0;
      t_addr[k] = '0;
      t_wd[k] = '0;
      lg_n[k] = 0;
      obs_acc[k] = 0;
      stb_cnt[k] = 0;
      for (int p = 0; p < 2; p++) begin
        addr[k][p] = '0;
        wd[k][p] = '0;
      end
      for (int i = 0; i < 1024; i++) rmem[k][i] = '0;
    end
    @(negedge clk);
    run_cycle();
    run_cycle();
    reset = 1'b0;
    mem_clr = 1'b0;
    live = 1'b1;

    // Both ports valid straight out of reset.
    set_req(0, 1'b0, 32'd3, 32'd0);
    set_req(1, 1'b1, 32'd3, 32'd12);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_ready", k, 32'(rdy[k]), 32'd1);
      chk("rst_rsp", k, 32'(rsp[k]), 32'd0);
      chk("rst_strobe", k, 32'({mr[k], mw[k]}), 32'd0);
      chk("rst_addr", k, maddr[k], 32'd0);
      chk("rst_rdata", k, rdata[k][0] | rdata[k][1], 32'd0);
    end
    wait_idle();
    set_req(0, 1'b0, 32'd3, 32'd0);
    set_req(1, 1'b1, 32'd5, 32'hA5);
    wait_idle();
    set_req(1, 1'b0, 32'd5, 32'd0);
    wait_idle();
    set_req(0, 1'b0, 32'h400, 32'd0);
    wait_idle();

    // Reset lands while the MEM_LAT=3 read is in WAIT.
    set_req(0, 1'b0, 32'd7, 32'd0);
    run_cycle();
    run_cycle();
    reset = 1'b1;
    run_cycle();
    reset = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("abort_strobe", k, 32'({mr[k], mw[k]}), 32'd0);
      chk("abort_rsp", k, 32'(rsp[k]), 32'd0);
    end
    set_req(0, 1'b0, 32'd3, 32'd0);
    set_req(1, 1'b0, 32'd5, 32'd0);
    wait_idle();
    set_req(1, 1'b0, 32'd5, 32'd0);
    wait_idle();

    for (int k = 0; k < 2; k++) begin
      chk("log_count", k, 32'(lg_n[k]), 32'd9);
      for (int i = 0; i < 9; i++) begin
        if (i < lg_n[k]) begin
          chk("log_port", k, 32'(lg_port[k][i]), 32'(xp_port[i]));
          chk("log_rdata", k, lg_rd[k][i], 32'(xp_rd[i]));
          chk("log_err", k, 32'(lg_err[k][i]), 32'(xp_err[i]));
          chk("log_latency", k, 32'(lg_lat[k][i]),
              32'(xp_err[i] == 1 ? 1 : lat_of(k) + 1));
          chk("log_strobes", k, 32'(lg_stb[k][i]),
              32'(xp_err[i] == 1 ? 0 : lat_of(k)));
        end
      end
    end

    mode_rand = 1'b1;
    repeat (4000) run_cycle();
    mode_rand = 1'b0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
